// File: rtl/btn_reader.sv
// Button reader: polarity correction, 2-flop synchronizer, per-button
// debounce counter, press/release pulses and an 8-bit press counter.
// The release pulse is named release_pulse because "release" is a reserved
// word in SystemVerilog.
module btn_reader #(
  parameter int unsigned      N_BTN      = 7,
  parameter int unsigned      DEBOUNCE   = 250000,
  parameter logic [N_BTN-1:0] ACTIVE_LOW = N_BTN'(7'b0000001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [7:0]       led
);

  localparam int unsigned CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] at_max;
  logic [N_BTN-1:0] change;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] accept_press;

  // A level change is accepted when the synchronized input has differed
  // from the stable level for DEBOUNCE consecutive cycles.
  always_comb begin
    at_max = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      at_max[i] = (cnt[i] == CNT_MAX);
    end
    change       = s2 ^ pressed;
    accept       = change & at_max;
    accept_press = accept & s2;
  end

  // Synchronizer, debounce counters, stable levels, pulses and press counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= '0;
      s2            <= '0;
      pressed       <= '0;
      press         <= '0;
      release_pulse <= '0;
      led           <= 8'd0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= btn ^ ACTIVE_LOW;
      s2 <= s1;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (!change[i]) begin
          cnt[i] <= '0;
        end else if (!at_max[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else begin
          cnt[i]     <= '0;
          pressed[i] <= s2[i];
        end
      end
      press         <= accept_press;
      release_pulse <= accept & ~s2;
      if (accept_press != '0) begin
        led <= led + 8'd1;
      end
    end
  end

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 Parameter N_BTN, default 7: number of button inputs.
REQ-002 Parameter DEBOUNCE, default 250000: consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW, default 7'b0000001: bit i = 1 means btn[i] reads 0 when pressed.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn  input  N_BTN  raw, asynchronous, bouncing button pins.
REQ-007 pressed  output  N_BTN  debounced level; 1 = button held, after polarity correction.
REQ-008 press  output  N_BTN  one-cycle pulse on each accepted press.
REQ-009 release  output  N_BTN  one-cycle pulse on each accepted release.
REQ-010 led  output  8  press counter for direct drive of the board LEDs.

Function
REQ-011 Each btn[i] SHALL be XORed with ACTIVE_LOW[i], then passed through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Each button SHALL have an independent debounce counter of ceil(log2(DEBOUNCE)) bits and a stable-level register; pressed[i] SHALL be that stable-level register.
REQ-013 When s2[i] == pressed[i], counter i SHALL load 0.
REQ-014 When s2[i] != pressed[i] and counter i < DEBOUNCE-1, counter i SHALL increment by 1.
REQ-015 When s2[i] != pressed[i] and counter i == DEBOUNCE-1, then on that same edge: pressed[i] SHALL load s2[i], counter i SHALL load 0, and press[i] (0->1) or release[i] (1->0) SHALL assert for exactly one cycle.
REQ-016 A glitch shorter than DEBOUNCE cycles at s2 SHALL produce no change on pressed, press, release or led.
REQ-017 Latency SHALL be fixed. If btn changes before edge k and stays stable, pressed changes and the pulse asserts after edge k+1+DEBOUNCE (2 synchronizer cycles plus DEBOUNCE counting cycles).
REQ-018 press and release for the same bit SHALL never be high in the same cycle.
REQ-019 Different bits SHALL be fully independent; simultaneous events on several bits SHALL each pulse.
REQ-020 led SHALL increment by 1, modulo 256, in every cycle where press is non-zero, regardless of how many bits are set; 255 wraps to 0.
REQ-021 release events SHALL NOT affect led.
REQ-022 All outputs SHALL be registered; no combinational path from btn to any output.

Reset
REQ-023 While rst = 1 at a clock edge, the following SHALL load 0: s1, s2, all counters, pressed, press, release and led.
REQ-024 Reset SHALL override any in-progress count; after release, a button held through reset SHALL be accepted as a press DEBOUNCE+2 cycles later, as a fresh 0->1 change.
REQ-025 The first active edge SHALL be the one following the edge at which rst is sampled 0; no asynchronous reset path SHALL exist.

Verification (DEBOUNCE=4, ACTIVE_LOW=7'b0000001, 25 MHz clk)
REQ-026 rst high 3 cycles with btn=7'b0000001 (all released) -> pressed=0, press=0, release=0, led=0 throughout and after reset.
REQ-027 btn[3] 0->1 before edge k, held -> pressed[3]=1 and press[3]=1 after edge k+5; press[3]=0 after edge k+6; led=1.
REQ-028 btn[3] pulses high for 3 cycles, then low, repeated 5 times -> pressed, press and led unchanged.
REQ-029 btn[0] driven 1->0 (active-low press) -> press[0] one cycle, led increments; btn[0] back to 1 -> release[0] one cycle, led unchanged.
REQ-030 btn[1] and btn[2] rise in the same cycle -> press=7'b0000110 for one cycle, led increments by exactly 1; 256 accepted presses from led=0 -> led=0 (wrap).
REQ-031 btn[5] held 3 cycles into its debounce window, then rst for 1 cycle -> counter cleared; with btn[5] still held, press[5] asserts 6 cycles after rst deasserts.
